// File: rtl/gesture_pkg.sv
// Shared types and default geometry for the gesture pipeline (palm locator, finger stage).
package gesture_pkg;
    localparam int IMAGE_WIDTH    = 120;
    localparam int IMAGE_HEIGHT   = 160;
    localparam int MIN_ROW_PIXELS = 8;
    localparam int COORD_W        = 8;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESOLVE
    } palm_state_t;
endpackage

// File: rtl/raster_counter.sv
// Row-major col/row position of the current pixel beat. A restart beat is pixel (0,0)
// regardless of the held count, so the next position is (1,0).
module raster_counter #(
    parameter int IMAGE_WIDTH  = gesture_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = gesture_pkg::IMAGE_HEIGHT,
    parameter int COORD_W      = gesture_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               restart,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row,
    output logic               last_col,
    output logic               last_pix
);
    localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(IMAGE_WIDTH - 1);
    localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(IMAGE_HEIGHT - 1);

    assign last_col = (col == COL_MAX);
    assign last_pix = last_col && (row == ROW_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (restart) begin
                col <= COORD_W'(1);
                row <= '0;
            end else if (last_col) begin
                col <= '0;
                row <= last_pix ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end
endmodule

// File: rtl/palm_locator.sv
// Scans a binary object raster and publishes the bounding box of rows with enough
// object pixels to be palm; width 0 tells the finger stage there is no palm.
module palm_locator
    import gesture_pkg::*;
#(
    parameter int IMAGE_WIDTH    = gesture_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT   = gesture_pkg::IMAGE_HEIGHT,
    parameter int MIN_ROW_PIXELS = gesture_pkg::MIN_ROW_PIXELS,
    parameter int COORD_W        = gesture_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pixel_valid,
    input  logic               frame_start,
    input  logic               pixel_in,
    output logic [COORD_W-1:0] start_of_palm_r,
    output logic [COORD_W-1:0] start_of_palm_c,
    output logic [COORD_W-1:0] end_of_palm_r,
    output logic [COORD_W-1:0] end_of_palm_c,
    output logic [COORD_W-1:0] palm_width,
    output logic [COORD_W-1:0] palm_height,
    output logic               palm_valid,
    output logic               busy
);
    typedef logic [COORD_W-1:0] crd_t;

    localparam crd_t COL_INIT = crd_t'(IMAGE_WIDTH - 1);
    localparam crd_t CNT_SAT  = crd_t'(IMAGE_WIDTH);
    localparam crd_t MIN_CNT  = crd_t'(MIN_ROW_PIXELS);

    palm_state_t state;

    crd_t cnt_col, cnt_row;
    logic cnt_last_col, cnt_last_pix;
    logic restart, advance, beat_last_col;
    crd_t beat_col, beat_row;

    // The final pixel wins over a coincident frame_start, so restart is blocked there.
    assign restart       = pixel_valid && frame_start &&
                           (state == IDLE || (state == SCAN && !cnt_last_pix));
    assign advance       = pixel_valid && (state == SCAN || restart);
    assign beat_col      = restart ? '0 : cnt_col;
    assign beat_row      = restart ? '0 : cnt_row;
    assign beat_last_col = cnt_last_col && !restart;

    raster_counter #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT),
        .COORD_W     (COORD_W)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .en      (advance),
        .restart (restart),
        .col     (cnt_col),
        .row     (cnt_row),
        .last_col(cnt_last_col),
        .last_pix(cnt_last_pix)
    );

    crd_t row_cnt, row_first, row_last;
    logic row_hit;
    crd_t min_c, max_c, start_r, end_r;
    logic found;

    crd_t cnt_nxt, first_nxt, last_nxt;
    logic hit_nxt, qualify;

    // Row statistics including the current beat's pixel.
    always_comb begin
        cnt_nxt   = restart ? '0 : row_cnt;
        first_nxt = restart ? '0 : row_first;
        last_nxt  = restart ? '0 : row_last;
        hit_nxt   = restart ? 1'b0 : row_hit;
        if (pixel_in) begin
            if (cnt_nxt != CNT_SAT)
                cnt_nxt = cnt_nxt + 1'b1;
            if (!hit_nxt)
                first_nxt = beat_col;
            last_nxt = beat_col;
            hit_nxt  = 1'b1;
        end
        qualify = (cnt_nxt >= MIN_CNT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt   <= '0;
            row_first <= '0;
            row_last  <= '0;
            row_hit   <= 1'b0;
            min_c     <= '0;
            max_c     <= '0;
            start_r   <= '0;
            end_r     <= '0;
            found     <= 1'b0;
        end else if (advance) begin
            if (beat_last_col) begin
                row_cnt   <= '0;
                row_first <= '0;
                row_last  <= '0;
                row_hit   <= 1'b0;
                if (qualify) begin
                    if (!found)
                        start_r <= beat_row;
                    end_r <= beat_row;
                    found <= 1'b1;
                    if (first_nxt < min_c)
                        min_c <= first_nxt;
                    if (last_nxt > max_c)
                        max_c <= last_nxt;
                end
            end else begin
                row_cnt   <= cnt_nxt;
                row_first <= first_nxt;
                row_last  <= last_nxt;
                row_hit   <= hit_nxt;
            end
            // A restart beat is never a last-column beat, so this cannot collide with a commit.
            if (restart) begin
                found   <= 1'b0;
                min_c   <= COL_INIT;
                max_c   <= '0;
                start_r <= '0;
                end_r   <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            start_of_palm_r <= '0;
            start_of_palm_c <= '0;
            end_of_palm_r   <= '0;
            end_of_palm_c   <= '0;
            palm_width      <= '0;
            palm_height     <= '0;
            palm_valid      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            palm_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (restart) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (pixel_valid && cnt_last_pix)
                        state <= RESOLVE;
                end
                RESOLVE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    palm_valid <= 1'b1;
                    if (found) begin
                        start_of_palm_r <= start_r;
                        start_of_palm_c <= min_c;
                        end_of_palm_r   <= end_r;
                        end_of_palm_c   <= max_c;
                        palm_width      <= max_c - min_c + 1'b1;
                        palm_height     <= end_r - start_r + 1'b1;
                    end else begin
                        start_of_palm_r <= '0;
                        start_of_palm_c <= '0;
                        end_of_palm_r   <= '0;
                        end_of_palm_c   <= '0;
                        palm_width      <= '0;
                        palm_height     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_palm_locator.sv
// Scoreboard bench: frames are drawn into an image array, the expected box is derived
// from row pixel counts and queued, and a monitor compares every palm_valid pulse.
module tb_palm_locator;
    localparam int W    = 72;
    localparam int H    = 84;
    localparam int MINP = 8;
    localparam int CW   = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pixel_valid = 1'b0;
    logic frame_start = 1'b0;
    logic pixel_in = 1'b0;
    logic [CW-1:0] sr, sc, er, ec, pw, ph;
    logic palm_valid, busy;

    palm_locator #(
        .IMAGE_WIDTH   (W),
        .IMAGE_HEIGHT  (H),
        .MIN_ROW_PIXELS(MINP),
        .COORD_W       (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pixel_valid    (pixel_valid),
        .frame_start    (frame_start),
        .pixel_in       (pixel_in),
        .start_of_palm_r(sr),
        .start_of_palm_c(sc),
        .end_of_palm_r  (er),
        .end_of_palm_c  (ec),
        .palm_width     (pw),
        .palm_height    (ph),
        .palm_valid     (palm_valid),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sr, sc, er, ec, w, h;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t published;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit img[H][W];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic check_outputs(input string pfx, input exp_t e);
        check({pfx, "_start_r"}, int'(sr), e.sr);
        check({pfx, "_start_c"}, int'(sc), e.sc);
        check({pfx, "_end_r"},   int'(er), e.er);
        check({pfx, "_end_c"},   int'(ec), e.ec);
        check({pfx, "_width"},   int'(pw), e.w);
        check({pfx, "_height"},  int'(ph), e.h);
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.sr = 0; e.sc = 0; e.er = 0; e.ec = 0; e.w = 0; e.h = 0; e.cyc = 0;
        return e;
    endfunction

    // Reference: a row is palm if it holds at least MINP object pixels; box spans those rows.
    function automatic exp_t model();
        exp_t e;
        int cnt, f, l, mn, mx;
        bit any;
        e = zero_exp();
        any = 0; mn = W - 1; mx = 0;
        for (int r = 0; r < H; r++) begin
            cnt = 0; f = -1; l = -1;
            for (int c = 0; c < W; c++)
                if (img[r][c]) begin
                    cnt++;
                    if (f < 0) f = c;
                    l = c;
                end
            if (cnt >= MINP) begin
                if (!any) e.sr = r;
                any = 1;
                e.er = r;
                if (f < mn) mn = f;
                if (l > mx) mx = l;
            end
        end
        if (any) begin
            e.sc = mn; e.ec = mx;
            e.w = mx - mn + 1;
            e.h = e.er - e.sr + 1;
        end else begin
            e = zero_exp();
        end
        return e;
    endfunction

    function automatic void clear_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 0;
    endfunction

    function automatic void fill(input int r0, input int r1, input int c0, input int c1);
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                img[r][c] = 1;
    endfunction

    function automatic void rand_img();
        int r0, r1, c0, c1;
        clear_img();
        r0 = $urandom_range(H - 20, 0);
        r1 = r0 + $urandom_range(15, 0);
        c0 = $urandom_range(W - 10, 0);
        c1 = c0 + $urandom_range(30, 6);
        if (c1 > W - 1) c1 = W - 1;
        fill(r0, r1, c0, c1);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if ($urandom_range(31, 0) == 0) img[r][c] = 1;
    endfunction

    task automatic beat(input bit fs, input bit px, input bit gaps);
        int g = 0;
        if (gaps)
            while ($urandom_range(1, 0) == 1 && g < 8) begin
                pixel_valid = 1'b0;
                pixel_in = $urandom_range(1, 0);
                frame_start = $urandom_range(1, 0);
                @(posedge clk); #1;
                g++;
            end
        pixel_valid = 1'b1;
        frame_start = fs;
        pixel_in = px;
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        pixel_in = 1'b0;
    endtask

    // stop_before < 0 sends the whole frame and queues its expected result.
    task automatic send_frame(input bit gaps, input int stop_before);
        exp_t e;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (r * W + c == stop_before) return;
                beat(r == 0 && c == 0, img[r][c], gaps);
            end
        e = model();
        e.cyc = cyc;
        exp_q.push_back(e);
        published = e;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_low_after_frame", int'(busy), 0);
    endtask

    // Pulse must appear on the edge right after the final beat's edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (palm_valid) begin
                check("pulse_was_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_outputs("pulse", e);
                    check("pulse_latency", cyc - e.cyc, 1);
                end
            end
        end
    end

    initial begin
        exp_t hold;
        published = zero_exp();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", zero_exp());
        check("reset_valid", int'(palm_valid), 0);
        check("reset_busy", int'(busy), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // All-black frame
        clear_img();
        send_frame(0, -1);
        wait_idle();

        // Solid box rows 40..79, cols 30..69
        clear_img(); fill(40, 79, 30, 69);
        send_frame(0, -1);
        wait_idle();

        // 7-pixel rows must be rejected; real box rows 10..19, cols 5..24
        clear_img(); fill(50, 65, 40, 46); fill(10, 19, 5, 24);
        send_frame(0, -1);
        wait_idle();

        // Box 2 with random pixel_valid gaps
        clear_img(); fill(40, 79, 30, 69);
        send_frame(1, -1);
        wait_idle();

        // Frame A publishes box 2, frame B aborted at row 50 by a clean box-3 frame
        send_frame(0, -1);
        wait_idle();
        hold = published;
        rand_img();
        send_frame(0, 50 * W);
        check_outputs("abort_hold", hold);
        clear_img(); fill(50, 65, 40, 46); fill(10, 19, 5, 24);
        send_frame(0, -1);
        wait_idle();

        // Reset mid-scan clears immediately
        rand_img();
        send_frame(0, 30 * W + 5);
        rst = 1'b0;
        #2;
        check_outputs("midscan_reset", zero_exp());
        check("midscan_reset_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        published = zero_exp();
        for (int i = 0; i < 150; i++)
            beat(0, $urandom_range(1, 0), 0);
        check("stray_beats_busy", int'(busy), 0);
        check_outputs("stray_beats_hold", published);
        rand_img();
        send_frame(0, -1);
        wait_idle();

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
